// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the RV32I multi-cycle controller and its datapath.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        br_taken;
    logic        imem_req;
    logic        ir_we;
    logic        is_pc;
    logic        is_imm;
    logic        dmem_req;
    logic        dmem_wr;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic        err;
    logic [31:0] instret;

    modport master (
        input  instr, imem_ready, dmem_ready, br_taken,
        output imem_req, ir_we, is_pc, is_imm, dmem_req, dmem_wr, rf_we,
               wb_sel, pc_we, pc_sel, state, err, instret
    );

    modport slave (
        output instr, imem_ready, dmem_ready, br_taken,
        input  imem_req, ir_we, is_pc, is_imm, dmem_req, dmem_wr, rf_we,
               wb_sel, pc_we, pc_sel, state, err, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I core with memory-wait timeout trap.
// Define MCCTRL_INSTRET_EN to build the retired-instruction counter; otherwise instret reads 0.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             err_q;

    logic [6:0] opcode;
    logic       legal, op_pc, op_imm;
    logic       is_load, is_store, is_branch, is_jump;
    logic       tmo_hit;
    logic       unused_instr;

    logic       imem_req_c, ir_we_c, is_pc_c, is_imm_c, dmem_req_c, dmem_wr_c;
    logic       rf_we_c, pc_we_c;
    logic [1:0] wb_sel_c, pc_sel_c;

    assign opcode       = bus.instr[6:0];
    assign unused_instr = ^bus.instr[31:7];
    assign is_load      = (opcode == OPC_LOAD);
    assign is_store     = (opcode == OPC_STORE);
    assign is_branch    = (opcode == OPC_BRANCH);
    assign is_jump      = (opcode == OPC_JAL) || (opcode == OPC_JALR);
    // Trap on the wait cycle that would bring the counter to MEM_TIMEOUT; a ready on that cycle wins.
    assign tmo_hit      = (MEM_TIMEOUT != 0) && (wait_q == CNT_W'(MEM_TIMEOUT - 1));

    // Opcode legality and ALU operand selects.
    always_comb begin
        legal  = 1'b1;
        op_pc  = 1'b0;
        op_imm = 1'b0;
        case (opcode)
            OPC_OP, OPC_BRANCH: ;
            OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_JALR, OPC_LUI: op_imm = 1'b1;
            OPC_JAL, OPC_AUIPC: begin
                op_pc  = 1'b1;
                op_imm = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        is_pc_c    = 1'b0;
        is_imm_c   = 1'b0;
        dmem_req_c = 1'b0;
        dmem_wr_c  = 1'b0;
        rf_we_c    = 1'b0;
        wb_sel_c   = 2'b00;
        pc_we_c    = 1'b0;
        pc_sel_c   = 2'b00;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                is_pc_c  = op_pc;
                is_imm_c = op_imm;
                if (is_branch) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = bus.br_taken ? 2'b10 : 2'b00;
                    state_d  = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // Operand selects stay at their EXEC values so the address is stable.
                is_pc_c    = op_pc;
                is_imm_c   = op_imm;
                dmem_req_c = 1'b1;
                dmem_wr_c  = is_store;
                if (bus.dmem_ready) begin
                    if (is_store) begin
                        pc_we_c = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_WB: begin
                rf_we_c  = 1'b1;
                pc_we_c  = 1'b1;
                wb_sel_c = is_load ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
                pc_sel_c = is_jump ? 2'b01 : 2'b00;
                state_d  = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_q | (state_d == S_TRAP);
        end
    end

    // Every output reads zero while reset is held.
    assign bus.imem_req = imem_req_c & ~reset;
    assign bus.ir_we    = ir_we_c    & ~reset;
    assign bus.is_pc    = is_pc_c    & ~reset;
    assign bus.is_imm   = is_imm_c   & ~reset;
    assign bus.dmem_req = dmem_req_c & ~reset;
    assign bus.dmem_wr  = dmem_wr_c  & ~reset;
    assign bus.rf_we    = rf_we_c    & ~reset;
    assign bus.pc_we    = pc_we_c    & ~reset;
    assign bus.wb_sel   = reset ? 2'b00 : wb_sel_c;
    assign bus.pc_sel   = reset ? 2'b00 : pc_sel_c;
    assign bus.state    = reset ? 3'd0  : state_q;
    assign bus.err      = err_q & ~reset;

`ifdef MCCTRL_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else if (pc_we_c) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign bus.instret = reset ? 32'd0 : instret_q;
`else
    assign bus.instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT=16).
module tb_multicycle_ctrl;
    localparam logic [31:0] I_ADD   = 32'h00208033;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_AUIPC = 32'h00001097;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_BAD   = 32'h00000000;
`ifdef MCCTRL_INSTRET_EN
    localparam logic [31:0] EXP_RET = 32'd10;
`else
    localparam logic [31:0] EXP_RET = 32'd0;
`endif

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Fetch with imem_ready high; returns with DECODE checked.
    task automatic fetch(input logic [31:0] ins);
        bus.instr      = ins;
        bus.imem_ready = 1'b1;
        #1;
        chk("fetch_state", 32'(bus.state), 0);
        chk("fetch_imem_req", 32'(bus.imem_req), 1);
        chk("fetch_ir_we", 32'(bus.ir_we), 1);
        nxt();
        bus.imem_ready = 1'b0;
        #1;
        chk("decode_state", 32'(bus.state), 1);
        chk("decode_ir_we", 32'(bus.ir_we), 0);
        chk("decode_pc_we", 32'(bus.pc_we), 0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.instr      = 32'd0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.br_taken   = 1'b0;

        // Reset state
        nxt();
        nxt();
        #1;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_imem_req", 32'(bus.imem_req), 0);
        chk("rst_instret", bus.instret, 0);
        reset = 1'b0;

        // ADD: 0,1,2,4,0
        fetch(I_ADD);
        nxt(); #1;
        chk("add_exec_state", 32'(bus.state), 2);
        chk("add_exec_is_pc", 32'(bus.is_pc), 0);
        chk("add_exec_is_imm", 32'(bus.is_imm), 0);
        chk("add_exec_pc_we", 32'(bus.pc_we), 0);
        nxt(); #1;
        chk("add_wb_state", 32'(bus.state), 4);
        chk("add_wb_rf_we", 32'(bus.rf_we), 1);
        chk("add_wb_wb_sel", 32'(bus.wb_sel), 0);
        chk("add_wb_pc_we", 32'(bus.pc_we), 1);
        chk("add_wb_pc_sel", 32'(bus.pc_sel), 0);
        chk("add_wb_is_imm", 32'(bus.is_imm), 0);
        nxt(); #1;
        chk("add_done_state", 32'(bus.state), 0);

        // LW with 3 wait cycles in MEM
        fetch(I_LW);
        nxt(); #1;
        chk("lw_exec_state", 32'(bus.state), 2);
        chk("lw_exec_is_imm", 32'(bus.is_imm), 1);
        for (int i = 0; i < 4; i++) begin
            nxt();
            bus.dmem_ready = (i == 3);
            #1;
            chk("lw_mem_state", 32'(bus.state), 3);
            chk("lw_mem_dmem_req", 32'(bus.dmem_req), 1);
            chk("lw_mem_dmem_wr", 32'(bus.dmem_wr), 0);
            chk("lw_mem_is_imm", 32'(bus.is_imm), 1);
            chk("lw_mem_pc_we", 32'(bus.pc_we), 0);
            chk("lw_mem_rf_we", 32'(bus.rf_we), 0);
        end
        nxt();
        bus.dmem_ready = 1'b0;
        #1;
        chk("lw_wb_state", 32'(bus.state), 4);
        chk("lw_wb_wb_sel", 32'(bus.wb_sel), 1);
        chk("lw_wb_rf_we", 32'(bus.rf_we), 1);
        chk("lw_wb_pc_we", 32'(bus.pc_we), 1);
        nxt(); #1;
        chk("lw_done_state", 32'(bus.state), 0);

        // SW: store retires in MEM, no regfile write
        fetch(I_SW);
        nxt(); #1;
        chk("sw_exec_rf_we", 32'(bus.rf_we), 0);
        nxt();
        bus.dmem_ready = 1'b1;
        #1;
        chk("sw_mem_state", 32'(bus.state), 3);
        chk("sw_mem_dmem_wr", 32'(bus.dmem_wr), 1);
        chk("sw_mem_pc_we", 32'(bus.pc_we), 1);
        chk("sw_mem_pc_sel", 32'(bus.pc_sel), 0);
        chk("sw_mem_rf_we", 32'(bus.rf_we), 0);
        nxt();
        bus.dmem_ready = 1'b0;
        #1;
        chk("sw_done_state", 32'(bus.state), 0);
        chk("sw_done_rf_we", 32'(bus.rf_we), 0);

        // BEQ taken, then not taken
        for (int t = 1; t >= 0; t--) begin
            fetch(I_BEQ);
            nxt();
            bus.br_taken = t[0];
            #1;
            chk("beq_exec_state", 32'(bus.state), 2);
            chk("beq_exec_pc_we", 32'(bus.pc_we), 1);
            chk("beq_exec_pc_sel", 32'(bus.pc_sel), (t == 1) ? 2 : 0);
            chk("beq_exec_rf_we", 32'(bus.rf_we), 0);
            nxt();
            bus.br_taken = 1'b0;
            #1;
            chk("beq_done_state", 32'(bus.state), 0);
            chk("beq_done_rf_we", 32'(bus.rf_we), 0);
        end

        // AUIPC
        fetch(I_AUIPC);
        nxt(); #1;
        chk("auipc_exec_is_pc", 32'(bus.is_pc), 1);
        chk("auipc_exec_is_imm", 32'(bus.is_imm), 1);
        nxt(); #1;
        chk("auipc_wb_state", 32'(bus.state), 4);
        chk("auipc_wb_wb_sel", 32'(bus.wb_sel), 0);
        chk("auipc_wb_pc_sel", 32'(bus.pc_sel), 0);
        chk("auipc_wb_is_pc", 32'(bus.is_pc), 0);
        nxt();

        // JAL
        fetch(I_JAL);
        nxt(); #1;
        chk("jal_exec_is_pc", 32'(bus.is_pc), 1);
        chk("jal_exec_is_imm", 32'(bus.is_imm), 1);
        nxt(); #1;
        chk("jal_wb_wb_sel", 32'(bus.wb_sel), 2);
        chk("jal_wb_pc_sel", 32'(bus.pc_sel), 1);
        chk("jal_wb_rf_we", 32'(bus.rf_we), 1);
        nxt(); #1;
        chk("jal_done_state", 32'(bus.state), 0);

        // Fetch timeout: 16 wait cycles then TRAP
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("tmo_wait_state", 32'(bus.state), 0);
            chk("tmo_wait_imem_req", 32'(bus.imem_req), 1);
            nxt();
        end
        #1;
        chk("tmo_trap_state", 32'(bus.state), 5);
        chk("tmo_trap_err", 32'(bus.err), 1);
        chk("tmo_trap_imem_req", 32'(bus.imem_req), 0);
        nxt();
        bus.imem_ready = 1'b1;
        #1;
        chk("trap_sticky_state", 32'(bus.state), 5);
        chk("trap_sticky_ir_we", 32'(bus.ir_we), 0);

        // Reset out of TRAP
        bus.imem_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("trap_rst_state", 32'(bus.state), 0);
        chk("trap_rst_err", 32'(bus.err), 0);
        nxt();
        reset = 1'b0;
        #1;
        chk("post_rst_state", 32'(bus.state), 0);
        chk("post_rst_err", 32'(bus.err), 0);
        chk("post_rst_imem_req", 32'(bus.imem_req), 1);

        // Ready arriving on the 16th wait cycle completes normally
        bus.instr = I_ADD;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("edge_wait_state", 32'(bus.state), 0);
            nxt();
        end
        fetch(I_ADD);
        nxt(); #1;
        chk("edge_exec_state", 32'(bus.state), 2);
        nxt(); #1;
        chk("edge_wb_state", 32'(bus.state), 4);
        chk("edge_err", 32'(bus.err), 0);
        nxt();

        // Illegal opcode traps from DECODE
        fetch(I_BAD);
        nxt(); #1;
        chk("bad_trap_state", 32'(bus.state), 5);
        chk("bad_trap_err", 32'(bus.err), 1);
        chk("bad_trap_rf_we", 32'(bus.rf_we), 0);

        // 10 ADDs then an illegal instruction: instret counts only the ADDs
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        #1;
        chk("ret_rst_instret", bus.instret, 0);
        for (int k = 0; k < 10; k++) begin
            fetch(I_ADD);
            nxt();
            nxt();
            nxt();
        end
        #1;
        chk("ret_state", 32'(bus.state), 0);
        chk("ret_instret_10", bus.instret, EXP_RET);
        fetch(I_BAD);
        nxt();
        nxt();
        #1;
        chk("ret_trap_state", 32'(bus.state), 5);
        chk("ret_trap_instret", bus.instret, EXP_RET);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
